systolic_mac_column: RTL and testbench

SYSTOLIC_MAC_COLUMN -- requirements
Module: systolic_mac_column

---
 rtl/systolic_mac_column_pkg.sv | 19 +
 rtl/systolic_mac_column_pe.sv | 28 ++
 rtl/systolic_mac_column_register_sync.sv | 15 +
 rtl/systolic_mac_column_signed_adder.sv | 19 +
 rtl/systolic_mac_column.sv | 77 +++++++
 tb/tb_systolic_mac_column.sv | 237 +++++++++++++++++++++++
 6 files changed

// File: rtl/systolic_mac_column_pkg.sv
// systolic_mac_column_pkg: shared widths, PE modes and chain-width derivation for the MAC column.
package systolic_mac_column_pkg;

    localparam int DEF_ARRAY_N   = 4;
    localparam int DEF_ACT_WIDTH = 16;
    localparam int DEF_WGT_WIDTH = 16;
    localparam int DEF_ACC_WIDTH = 48;

    typedef enum logic {
        MULT = 1'b0,
        FMA  = 1'b1
    } pe_mode_e;

    // Full product width plus enough growth bits to sum n products without overflow.
    function automatic int pe_out_width(input int n, input int act_w, input int wgt_w);
        return act_w + wgt_w + $clog2(n);
    endfunction

endpackage

// File: rtl/systolic_mac_column_pe.sv
// pe: registered signed multiply (MULT) or multiply-add onto the upstream partial sum (FMA).
module pe
    import systolic_mac_column_pkg::*;
#(
    parameter pe_mode_e MODE      = FMA,
    parameter int       ACT_WIDTH = DEF_ACT_WIDTH,
    parameter int       WGT_WIDTH = DEF_WGT_WIDTH,
    parameter int       OUT_WIDTH = pe_out_width(DEF_ARRAY_N, DEF_ACT_WIDTH, DEF_WGT_WIDTH)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic signed [ACT_WIDTH-1:0] a,
    input  logic signed [WGT_WIDTH-1:0] b,
    input  logic signed [OUT_WIDTH-1:0] p_in,
    output logic signed [OUT_WIDTH-1:0] p_out
);

    localparam int PW = ACT_WIDTH + WGT_WIDTH;

    logic signed [PW-1:0] prod;

    assign prod = PW'(a) * PW'(b);

    always_ff @(posedge clk or posedge reset)
        if (reset) p_out <= '0;
        else       p_out <= OUT_WIDTH'(prod) + (MODE == FMA ? p_in : '0);

endmodule

// File: rtl/systolic_mac_column_register_sync.sv
// register_sync: one-cycle register with asynchronous reset, used for skew and alignment delays.
module register_sync #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset)
        if (reset) q <= '0;
        else       q <= d;

endmodule

// File: rtl/systolic_mac_column_signed_adder.sv
// signed_adder: enabled registered adder, both operands sign-extended to the output width.
module signed_adder #(
    parameter int A_WIDTH   = 34,
    parameter int B_WIDTH   = 48,
    parameter int OUT_WIDTH = 48
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        en,
    input  logic signed [A_WIDTH-1:0]   a,
    input  logic signed [B_WIDTH-1:0]   b,
    output logic signed [OUT_WIDTH-1:0] sum
);

    always_ff @(posedge clk or posedge reset)
        if (reset)   sum <= '0;
        else if (en) sum <= OUT_WIDTH'(a) + OUT_WIDTH'(b);

endmodule

// File: rtl/systolic_mac_column.sv
// systolic_mac_column: skewed PE chain computing a signed dot product per sample, then an
// accumulator that either adds onto its previous result or onto a per-sample bias.
module systolic_mac_column
    import systolic_mac_column_pkg::*;
#(
    parameter int ARRAY_N   = DEF_ARRAY_N,
    parameter int ACT_WIDTH = DEF_ACT_WIDTH,
    parameter int WGT_WIDTH = DEF_WGT_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [ARRAY_N*ACT_WIDTH-1:0]   act_in,
    input  logic [ARRAY_N*WGT_WIDTH-1:0]   wgt_in,
    input  logic                           acc,
    input  logic [ACC_WIDTH-1:0]           bias_in,
    output logic                           out_valid,
    output logic [ACC_WIDTH-1:0]           out_data
);

    localparam int PE_OUT_WIDTH = pe_out_width(ARRAY_N, ACT_WIDTH, WGT_WIDTH);
    localparam int SW           = ACT_WIDTH + WGT_WIDTH;
    localparam int AW           = ACC_WIDTH + 2;

    logic signed [PE_OUT_WIDTH-1:0] p  [ARRAY_N+1];
    logic        [AW-1:0]           al [ARRAY_N+1];
    logic                           valid_al;
    logic                           acc_al;
    logic        [ACC_WIDTH-1:0]    bias_al;

    assign p[0]  = '0;
    assign al[0] = {in_valid, acc, bias_in};
    assign {valid_al, acc_al, bias_al} = al[ARRAY_N];

    genvar n, k;
    generate
        for (n = 0; n < ARRAY_N; n++) begin : g_lane
            logic [SW-1:0] sk [n+1];
            assign sk[0] = {act_in[n*ACT_WIDTH +: ACT_WIDTH], wgt_in[n*WGT_WIDTH +: WGT_WIDTH]};
            for (k = 0; k < n; k++) begin : g_skew
                register_sync #(.WIDTH(SW)) u_skew (.clk(clk), .reset(reset), .d(sk[k]), .q(sk[k+1]));
            end
            pe #(
                .MODE     (n == 0 ? MULT : FMA),
                .ACT_WIDTH(ACT_WIDTH),
                .WGT_WIDTH(WGT_WIDTH),
                .OUT_WIDTH(PE_OUT_WIDTH)
            ) u_pe (
                .clk  (clk),
                .reset(reset),
                .a    (sk[n][SW-1 -: ACT_WIDTH]),
                .b    (sk[n][WGT_WIDTH-1:0]),
                .p_in (p[n]),
                .p_out(p[n+1])
            );
            // Control travels alongside the chain so it meets its own sample's dot product.
            register_sync #(.WIDTH(AW)) u_align (.clk(clk), .reset(reset), .d(al[n]), .q(al[n+1]));
        end
    endgenerate

    signed_adder #(
        .A_WIDTH  (PE_OUT_WIDTH),
        .B_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH(ACC_WIDTH)
    ) u_acc (
        .clk  (clk),
        .reset(reset),
        .en   (valid_al),
        .a    (p[ARRAY_N]),
        .b    (acc_al ? out_data : bias_al),
        .sum  (out_data)
    );

    register_sync #(.WIDTH(1)) u_vld (.clk(clk), .reset(reset), .d(valid_al), .q(out_valid));

endmodule

// File: tb/tb_systolic_mac_column.sv
// tb_systolic_mac_column: directed-vector bench for the 4-PE MAC column.
module tb_systolic_mac_column;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [63:0] act_in;
    logic [63:0] wgt_in;
    logic        acc;
    logic [47:0] bias_in;
    logic        out_valid;
    logic [47:0] out_data;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    systolic_mac_column #(
        .ARRAY_N  (4),
        .ACT_WIDTH(16),
        .WGT_WIDTH(16),
        .ACC_WIDTH(48)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .act_in   (act_in),
        .wgt_in   (wgt_in),
        .acc      (acc),
        .bias_in  (bias_in),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    function automatic logic [63:0] pack4(input int x0, input int x1, input int x2, input int x3);
        return {x3[15:0], x2[15:0], x1[15:0], x0[15:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [63:0] a, input logic [63:0] w,
                         input logic ac, input logic [47:0] b);
        in_valid = v;
        act_in   = a;
        wgt_in   = w;
        acc      = ac;
        bias_in  = b;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle();
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: out_valid=%0b expected 0", out_valid); end
        n_checks++;
        if (out_data !== 48'd0) begin n_fail++; $display("FAIL reset_data: out_data=%0d expected 0", out_data); end
        reset = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0 || out_data !== 48'd0) begin
                n_fail++;
                $display("FAIL idle_after_reset e%0d: valid=%0b data=%0d expected 0/0", e, out_valid, out_data);
            end
        end
    endtask

    task automatic test_single();
        drive(1'b1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0, 48'd10);
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 1) idle();
            n_checks++;
            if (out_valid !== (e == 5)) begin
                n_fail++;
                $display("FAIL single_valid e%0d: out_valid=%0b expected %0b", e, out_valid, e == 5);
            end
            if (e >= 5) begin
                n_checks++;
                if (out_data !== 48'd80) begin n_fail++; $display("FAIL single_data e%0d: out_data=%0d expected 80", e, out_data); end
            end
        end
    endtask

    task automatic test_accumulate();
        drive(1'b1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0, 48'd10);
        step();
        drive(1'b1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1, 48'd999);
        step();
        idle();
        for (int e = 3; e <= 8; e++) begin
            step();
            n_checks++;
            if (out_valid !== (e == 5 || e == 6)) begin
                n_fail++;
                $display("FAIL accum_valid e%0d: out_valid=%0b expected %0b", e, out_valid, e == 5 || e == 6);
            end
            if (e >= 5) begin
                n_checks++;
                if (out_data !== (e == 5 ? 48'd80 : 48'd150)) begin
                    n_fail++;
                    $display("FAIL accum_data e%0d: out_data=%0d expected %0d", e, out_data, e == 5 ? 80 : 150);
                end
            end
        end
    endtask

    task automatic test_no_overflow();
        drive(1'b1, pack4(-32768, -32768, -32768, -32768), pack4(-32768, -32768, -32768, -32768),
              1'b0, 48'hFFFF_FFFF_FFFF);
        step();
        idle();
        for (int e = 2; e <= 5; e++) step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 48'd4294967295) begin
            n_fail++;
            $display("FAIL no_overflow: valid=%0b data=%0d expected 1/4294967295", out_valid, out_data);
        end
    endtask

    task automatic test_wrap();
        drive(1'b1, pack4(1, 0, 0, 0), pack4(1, 0, 0, 0), 1'b0, 48'h7FFF_FFFF_FFFF);
        step();
        idle();
        for (int e = 2; e <= 5; e++) step();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 48'h8000_0000_0000) begin
            n_fail++;
            $display("FAIL wrap: valid=%0b data=%h expected 1/800000000000", out_valid, out_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [47:0] exp_d [3];
        exp_d[0] = 48'd70;
        exp_d[1] = 48'd72;
        exp_d[2] = -48'sd195;
        drive(1'b1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0, 48'd0);
        step();
        drive(1'b1, pack4(-1, 2, -3, 4), pack4(1, 1, 1, 1), 1'b1, 48'd500);
        step();
        drive(1'b1, pack4(100, 0, 0, 0), pack4(-2, 0, 0, 0), 1'b0, 48'd5);
        step();
        idle();
        for (int e = 4; e <= 8; e++) begin
            step();
            n_checks++;
            if (out_valid !== (e >= 5 && e <= 7)) begin
                n_fail++;
                $display("FAIL b2b_valid e%0d: out_valid=%0b expected %0b", e, out_valid, e >= 5 && e <= 7);
            end
            if (e >= 5 && e <= 7) begin
                n_checks++;
                if (out_data !== exp_d[e-5]) begin
                    n_fail++;
                    $display("FAIL b2b_data e%0d: out_data=%h expected %h", e, out_data, exp_d[e-5]);
                end
            end
        end
    endtask

    task automatic test_gap();
        drive(1'b1, pack4(1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b0, 48'd0);
        step();
        drive(1'b0, pack4(100, 100, 100, 100), pack4(9, 9, 9, 9), 1'b1, 48'd77);
        step();
        drive(1'b1, pack4(1, 0, 0, 0), pack4(3, 0, 0, 0), 1'b1, 48'd0);
        step();
        idle();
        for (int e = 4; e <= 8; e++) begin
            step();
            n_checks++;
            if (out_valid !== (e == 5 || e == 7)) begin
                n_fail++;
                $display("FAIL gap_valid e%0d: out_valid=%0b expected %0b", e, out_valid, e == 5 || e == 7);
            end
            if (e >= 5) begin
                n_checks++;
                if (out_data !== (e >= 7 ? 48'd73 : 48'd70)) begin
                    n_fail++;
                    $display("FAIL gap_data e%0d: out_data=%0d expected %0d", e, out_data, e >= 7 ? 73 : 70);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, pack4(k + 1, 2, 3, 4), pack4(5, 6, 7, 8), 1'b1, 48'd10);
            if (k < 2) step();
        end
        #2;
        reset = 1'b1;
        idle();
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || out_data !== 48'd0) begin
            n_fail++;
            $display("FAIL async_reset: valid=%0b data=%0d expected 0/0", out_valid, out_data);
        end
        step();
        step();
        reset = 1'b0;
        for (int e = 1; e <= 10; e++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0 || out_data !== 48'd0) begin
                n_fail++;
                $display("FAIL midstream_flush e%0d: valid=%0b data=%0d expected 0/0", e, out_valid, out_data);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_accumulate();
        test_no_overflow();
        test_wrap();
        test_back_to_back();
        test_gap();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
